// File: rtl/enoc_switch_allocator.sv
// Switch allocator for an ENoC router: one round-robin arbiter per output port, with wormhole
// locking that keeps an output bound to one input from a packet's head flit through its tail flit.
module enoc_switch_allocator #(
  parameter int unsigned PORTS = 7,
  localparam int unsigned SW = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [0:PORTS-1][0:PORTS-1]      i_output_req,
  input  logic [0:PORTS-1]                 i_tail,
  input  logic [0:PORTS-1]                 i_en,
  output logic [0:PORTS-1][0:PORTS-1]      o_grant,
  output logic [0:PORTS-1]                 o_output_val,
  output logic [0:PORTS-1][SW-1:0]         o_sel
);

  typedef enum logic {StIdle, StLocked} mode_e;

  mode_e            mode_q  [PORTS];
  mode_e            mode_d  [PORTS];
  logic [SW-1:0]    owner_q [PORTS];
  logic [SW-1:0]    owner_d [PORTS];
  logic [SW-1:0]    ptr_q   [PORTS];
  logic [SW-1:0]    ptr_d   [PORTS];

  logic [PORTS-1:0]            req_col [PORTS];
  logic [0:PORTS-1][0:PORTS-1] grant;
  logic [0:PORTS-1]            val;
  logic [0:PORTS-1][SW-1:0]    sel;
  logic [SW:0]                 pick    [PORTS];

  // Returns {found, index} of the first set bit at or after ptr, wrapping at PORTS-1 -> 0.
  function automatic logic [SW:0] rr_pick(input logic [PORTS-1:0] col, input logic [SW-1:0] ptr);
    logic [SW:0] res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!res[SW] && col[idx]) res = {1'b1, idx[SW-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      req_col[o] = '0;
      for (int i = 0; i < PORTS; i++) req_col[o][i] = i_output_req[i][o];
    end
  end

  always_comb begin
    grant = '0;
    val   = '0;
    sel   = '0;
    for (int o = 0; o < PORTS; o++) begin
      mode_d[o]  = mode_q[o];
      owner_d[o] = owner_q[o];
      ptr_d[o]   = ptr_q[o];
      pick[o]    = rr_pick(req_col[o], ptr_q[o]);
      if (mode_q[o] == StLocked) begin
        // Only the owner may use a locked output; bubbles and backpressure hold the lock.
        sel[o] = owner_q[o];
        if (i_en[o] && i_output_req[owner_q[o]][o]) begin
          grant[owner_q[o]][o] = 1'b1;
          val[o]               = 1'b1;
          if (i_tail[owner_q[o]]) mode_d[o] = StIdle;
        end
      end else if (i_en[o] && pick[o][SW]) begin
        grant[pick[o][SW-1:0]][o] = 1'b1;
        val[o]                    = 1'b1;
        sel[o]                    = pick[o][SW-1:0];
        ptr_d[o] = (pick[o][SW-1:0] == SW'(PORTS - 1)) ? '0 : pick[o][SW-1:0] + SW'(1);
        if (!i_tail[pick[o][SW-1:0]]) begin
          mode_d[o]  = StLocked;
          owner_d[o] = pick[o][SW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int o = 0; o < PORTS; o++) begin
        mode_q[o]  <= StIdle;
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        mode_q[o]  <= mode_d[o];
        owner_q[o] <= owner_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

  // Outputs are forced quiet while reset is held, even if requests are present.
  assign o_grant      = reset_n ? grant : '0;
  assign o_output_val = reset_n ? val   : '0;
  assign o_sel        = reset_n ? sel   : '0;

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Bench for enoc_switch_allocator: directed scenarios with literal expectations, then randomized
// traffic, all checked every cycle against a behavioural per-output arbiter model.
module tb_enoc_switch_allocator;

  localparam int P  = 7;
  localparam int SW = 3;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [0:P-1][0:P-1]     req = '0;
  logic [0:P-1]            tail = '0;
  logic [0:P-1]            en = '0;
  logic [0:P-1][0:P-1]     grant;
  logic [0:P-1]            oval;
  logic [0:P-1][SW-1:0]    sel;

  int vectors = 0;
  int miscompares = 0;

  enoc_switch_allocator #(.PORTS(P)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_output_req (req),
    .i_tail       (tail),
    .i_en         (en),
    .o_grant      (grant),
    .o_output_val (oval),
    .o_sel        (sel)
  );

  always #5 clk = ~clk;

  // Behavioural model: per output a lock flag, owner and round-robin start index.
  bit m_locked [P];
  int m_owner  [P];
  int m_ptr    [P];
  int m_win    [P];
  logic [0:P-1][0:P-1]  exp_grant;
  logic [0:P-1]         exp_val;
  logic [0:P-1][SW-1:0] exp_sel;

  task automatic model_reset();
    for (int o = 0; o < P; o++) begin
      m_locked[o] = 0;
      m_owner[o]  = 0;
      m_ptr[o]    = 0;
    end
  endtask

  initial model_reset();

  task automatic model_eval();
    exp_grant = '0;
    exp_val   = '0;
    exp_sel   = '0;
    for (int o = 0; o < P; o++) begin
      m_win[o] = -1;
      if (en[o]) begin
        if (m_locked[o]) begin
          if (req[m_owner[o]][o]) m_win[o] = m_owner[o];
        end else begin
          for (int k = 0; k < P; k++) begin
            int i;
            i = (m_ptr[o] + k) % P;
            if (m_win[o] < 0 && req[i][o]) m_win[o] = i;
          end
        end
      end
      if (reset_n) begin
        if (m_win[o] >= 0) begin
          exp_grant[m_win[o]][o] = 1'b1;
          exp_val[o] = 1'b1;
        end
        if (m_locked[o]) exp_sel[o] = SW'(m_owner[o]);
        else if (m_win[o] >= 0) exp_sel[o] = SW'(m_win[o]);
      end
    end
  endtask

  task automatic model_update();
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int o = 0; o < P; o++) begin
      if (m_win[o] >= 0) begin
        if (m_locked[o]) begin
          if (tail[m_win[o]]) m_locked[o] = 0;
        end else begin
          m_ptr[o] = (m_win[o] + 1) % P;
          if (!tail[m_win[o]]) begin
            m_locked[o] = 1;
            m_owner[o]  = m_win[o];
          end
        end
      end
    end
  endtask

  // Single compare process: outputs are checked on the falling edge, then the model advances.
  always @(negedge clk) begin
    for (int i = 0; i < P; i++)
      assert ($onehot0(req[i])) else $error("illegal non-one-hot request row %0d", i);
    model_eval();
    vectors++;
    if (grant !== exp_grant || oval !== exp_val || sel !== exp_sel) begin
      miscompares++;
      $display("FAIL model t=%0t: grant=%h val=%b sel=%h required grant=%h val=%b sel=%h",
               $time, grant, oval, sel, exp_grant, exp_val, exp_sel);
    end
    model_update();
  end

  task automatic chk(input string name, input int got, input int required);
    vectors++;
    if (got != required) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, got, required);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  int rr_exp [6] = '{0, 3, 4, 0, 3, 4};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_grant", int'(|grant), 0);
    reset_n = 1'b1;
    en = '1;

    // Single flit n -> e, then ptr[2]=2 must favour input 3 over input 1.
    req[1][2] = 1'b1;
    tail = '1;
    settle();
    chk("single_grant", int'(grant[1][2]), 1);
    chk("single_sel", int'(sel[2]), 1);
    chk("single_val", int'(oval[2]), 1);
    advance();
    req[3][2] = 1'b1;
    settle();
    chk("ptr_after_single", int'(sel[2]), 3);
    advance();

    // Round-robin on output 0.
    req = '0;
    req[0][0] = 1'b1;
    req[3][0] = 1'b1;
    req[4][0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      chk("rr_sel", int'(sel[0]), rr_exp[k]);
      chk("rr_grant", int'(grant[rr_exp[k]][0]), 1);
      advance();
    end

    // Wormhole: 4-flit packet 2 -> 5 against single-flit requester 6.
    req = '0;
    tail = '0;
    tail[6] = 1'b1;
    req[2][5] = 1'b1;
    req[6][5] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tail[2] = (j == 3);
      settle();
      chk("worm_owner", int'(grant[2][5]), 1);
      chk("worm_block", int'(grant[6][5]), 0);
      advance();
    end
    req[2] = '0;
    settle();
    chk("worm_next", int'(grant[6][5]), 1);
    advance();

    // Backpressure then bubble mid-packet on output 5.
    tail[2] = 1'b0;
    req[2][5] = 1'b1;
    settle();
    chk("bp_head", int'(grant[2][5]), 1);
    advance();
    en[5] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      settle();
      chk("bp_val", int'(oval[5]), 0);
      chk("bp_sel", int'(sel[5]), 2);
      advance();
    end
    en[5] = 1'b1;
    req[2] = '0;
    for (int j = 0; j < 2; j++) begin
      settle();
      chk("bubble_val", int'(oval[5]), 0);
      chk("bubble_sel", int'(sel[5]), 2);
      advance();
    end
    req[2][5] = 1'b1;
    tail[2] = 1'b1;
    settle();
    chk("resume", int'(grant[2][5]), 1);
    advance();
    req[2] = '0;
    settle();
    chk("after_tail", int'(grant[6][5]), 1);
    advance();

    // Permutation: input i -> output (i+3)%7, all in one cycle.
    req = '0;
    tail = '1;
    for (int i = 0; i < P; i++) req[i][(i + 3) % P] = 1'b1;
    settle();
    chk("perm_val", int'(oval), 7'h7f);
    for (int o = 0; o < P; o++) chk("perm_sel", int'(sel[o]), (o + 4) % P);
    advance();

    // Reset while output 3 is locked to input 4.
    req = '0;
    tail = '0;
    req[4][3] = 1'b1;
    settle();
    chk("lock_head", int'(grant[4][3]), 1);
    advance();
    reset_n = 1'b0;
    #1;
    chk("rst_grant", int'(|grant), 0);
    chk("rst_val", int'(|oval), 0);
    advance();
    reset_n = 1'b1;
    req = '0;
    req[1][3] = 1'b1;
    settle();
    chk("post_rst_grant", int'(grant[1][3]), 1);
    advance();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < P; i++) begin
        int r;
        r = $urandom_range(0, P + 2);
        req[i] = '0;
        if (r < P) req[i][r] = 1'b1;
        tail[i] = ($urandom_range(0, 3) == 0);
      end
      for (int o = 0; o < P; o++) en[o] = ($urandom_range(0, 4) != 0);
      reset_n = ($urandom_range(0, 299) != 0);
      advance();
    end
    reset_n = 1'b1;
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
